// File: rtl/zynq_tag_sequencer.sv
// zynq_tag_sequencer: serializes bsg_tag packets onto the single-bit tag line.
// After reset it optionally sweeps a client reset packet to every node, then
// accepts one command at a time and shifts it out followed by an idle gap.
module zynq_tag_sequencer #(
  parameter int els_p               = 16,
  parameter int max_payload_width_p = 1,
  parameter int gap_p               = 2,
  parameter bit boot_reset_p        = 1'b1,
  localparam int lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int lg_width_lp = ((max_payload_width_p + 1) > 1) ? $clog2(max_payload_width_p + 1) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_and_o,
  input  logic [lg_els_lp-1:0]           nodeid_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_lp-1:0]         len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           tag_data_o,
  output logic                           boot_done_o,
  output logic                           err_o
);

  // Everything after the start bit: len, data_not_reset, nodeid, payload
  localparam int body_w_lp = lg_width_lp + 1 + lg_els_lp + max_payload_width_p;
  localparam int cnt_w_lp  = $clog2(body_w_lp + 1);
  localparam int gap_w_lp  = (gap_p > 0) ? $clog2(gap_p + 1) : 1;

  localparam logic [lg_width_lp-1:0] max_len_lp   = lg_width_lp'(max_payload_width_p);
  localparam logic [lg_els_lp-1:0]   last_node_lp = lg_els_lp'(els_p - 1);
  localparam logic [gap_w_lp-1:0]    gap_load_lp  = gap_w_lp'((gap_p > 0) ? gap_p - 1 : 0);
  localparam logic [cnt_w_lp-1:0]    hdr_bits_lp  = cnt_w_lp'(1 + lg_width_lp + lg_els_lp);

  typedef enum logic [1:0] {ST_START, ST_IDLE, ST_SEND, ST_GAP} state_e;

  state_e                   state_r;
  logic [body_w_lp-1:0]     shift_r;
  logic [cnt_w_lp-1:0]      bits_left_r;
  logic [gap_w_lp-1:0]      gap_cnt_r;
  logic [lg_els_lp-1:0]     node_r;
  logic                     booting_r;

  logic                           handshake, cmd_legal, load_cmd, load_boot, pkt_done;
  logic [lg_width_lp-1:0]         pkt_len;
  logic                           pkt_dnr;
  logic [lg_els_lp-1:0]           pkt_node;
  logic [max_payload_width_p-1:0] pkt_payload, payload_aligned;
  logic [body_w_lp-1:0]           pkt_body;

  // Decide whether a packet starts this cycle and assemble its body bits
  always_comb begin
    handshake = (state_r == ST_IDLE) && v_i && ready_and_o;
    cmd_legal = (len_i <= max_len_lp);
    load_cmd  = handshake && cmd_legal;
    pkt_done  = ((state_r == ST_SEND) && (bits_left_r == '0) && (gap_p == 0))
             || ((state_r == ST_GAP) && (gap_cnt_r == '0));
    load_boot = ((state_r == ST_START) && boot_reset_p)
             || (pkt_done && booting_r && (node_r != last_node_lp));

    pkt_len     = max_len_lp;
    pkt_dnr     = 1'b0;
    pkt_node    = (state_r == ST_START) ? '0 : node_r + lg_els_lp'(1);
    pkt_payload = '0;
    if (load_cmd) begin
      pkt_len     = len_i;
      pkt_dnr     = data_not_reset_i;
      pkt_node    = nodeid_i;
      pkt_payload = payload_i;
    end

    // Left-align the used payload bits so they leave MSB first; unused upper
    // bits fall off the top of the shift.
    payload_aligned = pkt_payload << (max_len_lp - pkt_len);
    pkt_body        = {pkt_len, pkt_dnr, pkt_node, payload_aligned};
  end

  // Sequencer FSM: boot sweep, command accept, bit shifting and gap timing
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= ST_START;
      shift_r     <= '0;
      bits_left_r <= '0;
      gap_cnt_r   <= '0;
      node_r      <= '0;
      booting_r   <= 1'b0;
      tag_data_o  <= 1'b0;
      ready_and_o <= 1'b0;
      boot_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o <= handshake && !cmd_legal;
      if (load_cmd || load_boot) begin
        state_r     <= ST_SEND;
        tag_data_o  <= 1'b1;
        shift_r     <= pkt_body;
        bits_left_r <= hdr_bits_lp + cnt_w_lp'(pkt_len);
        ready_and_o <= 1'b0;
        booting_r   <= load_boot;
        if (load_boot) node_r <= pkt_node;
      end else begin
        case (state_r)
          ST_START: begin
            state_r     <= ST_IDLE;
            ready_and_o <= 1'b1;
            boot_done_o <= 1'b1;
          end
          ST_IDLE: begin
            tag_data_o <= 1'b0;
          end
          ST_SEND: begin
            if (bits_left_r != '0) begin
              tag_data_o  <= shift_r[body_w_lp-1];
              shift_r     <= {shift_r[body_w_lp-2:0], 1'b0};
              bits_left_r <= bits_left_r - cnt_w_lp'(1);
            end else begin
              tag_data_o <= 1'b0;
              if (gap_p > 0) begin
                state_r   <= ST_GAP;
                gap_cnt_r <= gap_load_lp;
              end else begin
                state_r     <= ST_IDLE;
                ready_and_o <= 1'b1;
                boot_done_o <= 1'b1;
                booting_r   <= 1'b0;
              end
            end
          end
          ST_GAP: begin
            tag_data_o <= 1'b0;
            if (gap_cnt_r != '0) begin
              gap_cnt_r <= gap_cnt_r - gap_w_lp'(1);
            end else begin
              state_r     <= ST_IDLE;
              ready_and_o <= 1'b1;
              boot_done_o <= 1'b1;
              booting_r   <= 1'b0;
            end
          end
          default: state_r <= ST_START;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zynq_tag_sequencer.sv
// Testbench for zynq_tag_sequencer: three instances (defaults, no-boot with
// zero gap, wider payload with illegal lengths) driven with directed vectors.
module tb_zynq_tag_sequencer;

  typedef struct packed {
    logic       v;
    logic [3:0] node;
    logic       dnr;
    logic [1:0] len;
    logic [1:0] payload;
  } cmd_t;

  typedef struct {
    cmd_t        cmd;
    logic [15:0] bits;
    int          len;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       v1, dnr1, ready1, tag1, done1, err1;
  logic [3:0] node1;
  logic [0:0] len1, pay1;

  logic       v2, dnr2, ready2, tag2, done2, err2;
  logic [3:0] node2;
  logic [0:0] len2, pay2;

  logic       v3, dnr3, ready3, tag3, done3, err3;
  logic [3:0] node3;
  logic [1:0] len3, pay3;

  int compared = 0;
  int mismatched = 0;

  vec_t vectors [5];

  // Free-running clock
  always #5 clk = ~clk;

  zynq_tag_sequencer dut1 (
    .clk_i(clk), .reset_i(reset), .v_i(v1), .ready_and_o(ready1),
    .nodeid_i(node1), .data_not_reset_i(dnr1), .len_i(len1), .payload_i(pay1),
    .tag_data_o(tag1), .boot_done_o(done1), .err_o(err1)
  );

  zynq_tag_sequencer #(.els_p(16), .max_payload_width_p(1), .gap_p(0), .boot_reset_p(1'b0)) dut2 (
    .clk_i(clk), .reset_i(reset), .v_i(v2), .ready_and_o(ready2),
    .nodeid_i(node2), .data_not_reset_i(dnr2), .len_i(len2), .payload_i(pay2),
    .tag_data_o(tag2), .boot_done_o(done2), .err_o(err2)
  );

  zynq_tag_sequencer #(.els_p(16), .max_payload_width_p(2), .gap_p(1), .boot_reset_p(1'b0)) dut3 (
    .clk_i(clk), .reset_i(reset), .v_i(v3), .ready_and_o(ready3),
    .nodeid_i(node3), .data_not_reset_i(dnr3), .len_i(len3), .payload_i(pay3),
    .tag_data_o(tag3), .boot_done_o(done3), .err_o(err3)
  );

  function automatic cmd_t mkCmd(logic v, logic [3:0] node, logic dnr, logic [1:0] len, logic [1:0] payload);
    cmd_t c;
    c.v = v; c.node = node; c.dnr = dnr; c.len = len; c.payload = payload;
    return c;
  endfunction

  function automatic cmd_t scramble();
    return mkCmd(1'b0, 4'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
  endfunction

  // Status nibble: {tag_data, ready_and, boot_done, err}
  function automatic logic [3:0] getStatus(int which);
    case (which)
      1:       return {tag1, ready1, done1, err1};
      2:       return {tag2, ready2, done2, err2};
      default: return {tag3, ready3, done3, err3};
    endcase
  endfunction

  // Expected tag bit during the default boot sweep at cycle c
  function automatic logic bootBit(int c);
    logic [7:0] p;
    int k, off;
    if (c < 1) return 1'b0;
    k = (c - 1) / 10;
    off = (c - 1) % 10;
    if (k >= 16 || off >= 8) return 1'b0;
    p = {2'b11, 1'b0, 4'(k), 1'b0};
    return p[7 - off];
  endfunction

  task automatic applyStimulus(int which, cmd_t c);
    case (which)
      1: begin v1 = c.v; node1 = c.node; dnr1 = c.dnr; len1 = c.len[0:0]; pay1 = c.payload[0:0]; end
      2: begin v2 = c.v; node2 = c.node; dnr2 = c.dnr; len2 = c.len[0:0]; pay2 = c.payload[0:0]; end
      default: begin v3 = c.v; node3 = c.node; dnr3 = c.dnr; len3 = c.len; pay3 = c.payload; end
    endcase
  endtask

  task automatic checkOutput(string name, logic [3:0] actual, logic [3:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got {tag,rdy,done,err}=%b, expected %b", name, actual, expected);
    end
  endtask

  task automatic waitReady(int which, int budget);
    int n = 0;
    logic [3:0] s;
    s = getStatus(which);
    while (s[2] !== 1'b1 && n < budget) begin
      @(negedge clk);
      s = getStatus(which);
      n++;
    end
    checkOutput($sformatf("ready_wait_dut%0d", which), {3'b000, s[2]}, 4'b0001);
  endtask

  // Called at the negedge of the handshake cycle; checks bits, gap and ready return
  task automatic checkPacket(int which, string name, logic [15:0] bits, int len, int gap, cmd_t next);
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_bit%0d", name, i), getStatus(which), {bits[len - i], 3'b010});
      if (i == 1) applyStimulus(which, next);
    end
    for (int g = 1; g <= gap; g++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_gap%0d", name, g), getStatus(which), 4'b0010);
    end
    @(negedge clk);
    checkOutput($sformatf("%s_ready", name), getStatus(which), 4'b0110);
  endtask

  // Called at the negedge of cycle 0; checks all three instances through cycle 170
  task automatic bootSweep(string name);
    logic dn;
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      dn = (c >= 161);
      checkOutput($sformatf("%s_d1_c%0d", name, c), getStatus(1), {bootBit(c), dn, dn, 1'b0});
      checkOutput($sformatf("%s_d2_c%0d", name, c), getStatus(2), 4'b0110);
      checkOutput($sformatf("%s_d3_c%0d", name, c), getStatus(3), 4'b0110);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Main directed test sequence
  initial begin
    cmd_t c_idle;
    c_idle = mkCmd(1'b0, 4'd0, 1'b0, 2'd0, 2'd0);
    applyStimulus(1, c_idle);
    applyStimulus(2, c_idle);
    applyStimulus(3, c_idle);

    vectors[0] = '{mkCmd(1'b1, 4'd5,  1'b1, 2'd1, 2'd1), 16'h00EB, 8, "n5_data"};
    vectors[1] = '{mkCmd(1'b1, 4'd10, 1'b0, 2'd1, 2'd0), 16'h00D4, 8, "n10_reset"};
    vectors[2] = '{mkCmd(1'b1, 4'd15, 1'b1, 2'd0, 2'd1), 16'h005F, 7, "n15_len0"};
    vectors[3] = '{mkCmd(1'b1, 4'd0,  1'b1, 2'd1, 2'd1), 16'h00E1, 8, "n0_data"};
    vectors[4] = '{mkCmd(1'b1, 4'd3,  1'b1, 2'd0, 2'd0), 16'h0053, 7, "n3_len0"};

    $display("[TB] reset and boot sweep");
    repeat (3) @(negedge clk);
    checkOutput("reset_d1", getStatus(1), 4'b0000);
    checkOutput("reset_d2", getStatus(2), 4'b0000);
    checkOutput("reset_d3", getStatus(3), 4'b0000);
    reset = 1'b0;
    bootSweep("boot1");

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) begin
      waitReady(1, 40);
      applyStimulus(1, vectors[i].cmd);
      checkPacket(1, vectors[i].name, vectors[i].bits, vectors[i].len, 2, scramble());
    end

    $display("[TB] back-to-back with inputs changed mid-packet");
    waitReady(1, 40);
    applyStimulus(1, mkCmd(1'b1, 4'd12, 1'b1, 2'd1, 2'd0));
    checkPacket(1, "b2b_a", 16'h00F8, 8, 2, mkCmd(1'b1, 4'd6, 1'b0, 2'd1, 2'd1));
    checkPacket(1, "b2b_b", 16'h00CD, 8, 2, scramble());

    $display("[TB] no-boot instance, len 0, zero gap");
    waitReady(2, 40);
    applyStimulus(2, mkCmd(1'b1, 4'd6, 1'b1, 2'd0, 2'd1));
    checkPacket(2, "nb_len0", 16'h0056, 7, 0, c_idle);

    $display("[TB] illegal length then back-to-back legal commands");
    waitReady(3, 40);
    applyStimulus(3, mkCmd(1'b1, 4'd9, 1'b1, 2'd3, 2'd3));
    @(negedge clk);
    checkOutput("illegal_err", getStatus(3), 4'b0111);
    applyStimulus(3, mkCmd(1'b1, 4'd9, 1'b1, 2'd2, 2'd2));
    checkPacket(3, "w2_len2", 16'h0366, 10, 1, scramble());
    applyStimulus(3, mkCmd(1'b1, 4'd2, 1'b0, 2'd1, 2'd2));
    checkPacket(3, "w2_mask", 16'h0144, 9, 1, c_idle);

    $display("[TB] reset mid-packet");
    waitReady(1, 40);
    applyStimulus(1, mkCmd(1'b1, 4'd13, 1'b1, 2'd1, 2'd1));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_bit%0d", i), getStatus(1), 4'b1010);
      if (i == 1) applyStimulus(1, c_idle);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_first", getStatus(1), 4'b0000);
    @(negedge clk);
    checkOutput("mid_rst_second", getStatus(1), 4'b0000);
    reset = 1'b0;
    bootSweep("boot2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
